// File: rtl/keypad_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_queue_if
//  Description : Bundle between the keypad event queue and its consumer.
//                Carries the decoded key code into the queue and the event
//                valid/ready handshake, held-key status and overflow flag out.
//  Modports    : master - the event queue (produces events, consumes keys)
//                slave  - the decoder/consumer side (drives keys and ready)
//  Signals     : keyValue[3:0]  decoded key code, 0-8 valid, 9-15 none
//                evtReady       consumer accepts the head event
//                clrOverflow    clears the sticky overflow flag
//                evtValid       event queue non-empty
//                evtCode[3:0]   head event key code
//                heldKey[3:0]   debounced held key, 9 when none
//                overflow       a confirmed press was dropped (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_event_queue_if;
    logic [3:0] keyValue;
    logic       evtReady;
    logic       clrOverflow;
    logic       evtValid;
    logic [3:0] evtCode;
    logic [3:0] heldKey;
    logic       overflow;

    modport master (
        input  keyValue,
        input  evtReady,
        input  clrOverflow,
        output evtValid,
        output evtCode,
        output heldKey,
        output overflow
    );

    modport slave (
        output keyValue,
        output evtReady,
        output clrOverflow,
        input  evtValid,
        input  evtCode,
        input  heldKey,
        input  overflow
    );
endinterface
`default_nettype wire

// File: rtl/keypad_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_queue
//  Description : Debounces the per-cycle decoded keypad code over 4-cycle
//                row-scan windows, turns each confirmed press into a single
//                event and queues events in a first-word-fall-through FIFO
//                behind a valid/ready handshake. Also reports the held key.
//  Ports       : clk_100Hz  scan clock shared with the keypad decoder
//                reset      asynchronous, active-low
//                kp_io      keypad_event_queue_if.master (keys in, events out)
//  Parameters  : DEBOUNCE_WIN  clean windows to confirm a press (1-7)
//                RELEASE_WIN   empty windows to confirm a release (1-7)
//                FIFO_DEPTH    event queue depth, power of two (2-16)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_queue #(
    parameter int DEBOUNCE_WIN = 3,
    parameter int RELEASE_WIN  = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk_100Hz,
    input  logic                   reset,
    keypad_event_queue_if.master   kp_io
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0]       DEB_CNT = 3'(DEBOUNCE_WIN);
    localparam logic [2:0]       REL_CNT = 3'(RELEASE_WIN);
    localparam logic [3:0]       NO_KEY  = 4'd9;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESSING  = 2'd1,
        S_HELD      = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Window sampling
    // ------------------------------------------------------------------
    logic [1:0] phase_q;
    logic       win_seen_q, win_seen_d;
    logic [3:0] win_code_q, win_code_d;
    logic       win_conf_q, win_conf_d;

    logic       sample_ok;
    logic       seen_now;
    logic [3:0] code_now;
    logic       conf_now;
    logic       win_end;
    logic       win_empty;
    logic       win_clean;

    // The evaluation on phase 3 must include that cycle's own sample, so the
    // window classification is built from the registered state plus the
    // current code rather than from the registers alone.
    always_comb begin
        sample_ok = (kp_io.keyValue <= 4'd8);
        seen_now  = win_seen_q | sample_ok;
        code_now  = win_seen_q ? win_code_q : kp_io.keyValue;
        conf_now  = win_conf_q |
                    (win_seen_q & sample_ok & (kp_io.keyValue != win_code_q));
        win_end   = (phase_q == 2'd3);
        win_empty = ~seen_now;
        win_clean = seen_now & ~conf_now;

        if (win_end) begin
            win_seen_d = 1'b0;
            win_code_d = 4'd0;
            win_conf_d = 1'b0;
        end else begin
            win_seen_d = seen_now;
            win_code_d = code_now;
            win_conf_d = conf_now;
        end
    end

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            phase_q    <= 2'd0;
            win_seen_q <= 1'b0;
            win_code_q <= 4'd0;
            win_conf_q <= 1'b0;
        end else begin
            phase_q    <= phase_q + 2'd1;
            win_seen_q <= win_seen_d;
            win_code_q <= win_code_d;
            win_conf_q <= win_conf_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM, advanced only at window end
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cand_q,  cand_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       push;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        if (win_end) begin
            case (state_q)
                S_IDLE: begin
                    if (win_clean) begin
                        cand_d = code_now;
                        if (DEB_CNT == 3'd1) begin
                            state_d = S_HELD;
                            cnt_d   = 3'd0;
                            push    = 1'b1;
                        end else begin
                            state_d = S_PRESSING;
                            cnt_d   = 3'd1;
                        end
                    end
                end
                S_PRESSING: begin
                    if (win_clean) begin
                        if (code_now == cand_q) begin
                            if (cnt_q + 3'd1 == DEB_CNT) begin
                                state_d = S_HELD;
                                cnt_d   = 3'd0;
                                push    = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else begin
                            // A different key restarts the count on it.
                            cand_d = code_now;
                            cnt_d  = 3'd1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end
                end
                S_HELD: begin
                    if (win_empty) begin
                        if (REL_CNT == 3'd1) begin
                            state_d = S_IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            state_d = S_RELEASING;
                            cnt_d   = 3'd1;
                        end
                    end else begin
                        // Same key, a second key or a conflict: keep holding.
                        cnt_d = 3'd0;
                    end
                end
                S_RELEASING: begin
                    if (win_empty) begin
                        if (cnt_q + 3'd1 == REL_CNT) begin
                            state_d = S_IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (win_clean) begin
                        if (code_now == cand_q) begin
                            // Bounce during release: resume holding, no event.
                            state_d = S_HELD;
                            cnt_d   = 3'd0;
                        end else begin
                            cand_d  = code_now;
                            cnt_d   = 3'd1;
                            state_d = S_PRESSING;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic fifo_valid;
    logic fifo_full;
    logic pop;
    logic wr_en;

    always_comb begin
        fifo_valid = (count_q != '0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = fifo_valid & kp_io.evtReady;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        wr_en      = push & (~fifo_full | pop);

        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Set has priority over clear.
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (kp_io.clrOverflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: reads are masked while the queue is empty.
    always_ff @(posedge clk_100Hz) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cand_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        kp_io.evtValid = fifo_valid;
        kp_io.evtCode  = fifo_valid ? mem_q[rd_ptr_q] : 4'd0;
        kp_io.heldKey  = ((state_q == S_HELD) || (state_q == S_RELEASING))
                         ? cand_q : NO_KEY;
        kp_io.overflow = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_event_queue
//  Description : Self-checking bench for keypad_event_queue. Stimulus is
//                applied in whole 4-cycle windows; expected event codes are
//                queued when a press is expected to confirm and compared as
//                the DUT hands events out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_event_queue;

    logic clk;
    logic reset;

    keypad_event_queue_if kp_if ();

    keypad_event_queue #(
        .DEBOUNCE_WIN (3),
        .RELEASE_WIN  (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_100Hz (clk),
        .reset     (reset),
        .kp_io     (kp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_q [$];

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event consumer: sample on the falling edge, where evtReady already
    // holds the value the next rising edge will act on.
    always @(negedge clk) begin
        if (reset && kp_if.evtValid && kp_if.evtReady) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_evt", int'(kp_if.evtValid), 0);
            end else begin
                check_val("evt_code", int'(kp_if.evtCode), int'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive the code just after a rising edge, hold to the next.
    task automatic cyc(input logic [3:0] k);
        kp_if.keyValue = k;
        @(posedge clk);
        #1;
    endtask

    task automatic win(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
        cyc(a); cyc(b); cyc(c); cyc(d);
    endtask

    task automatic press(input logic [3:0] k);
        win(4'd9, k, 4'd9, 4'd9);
        win(4'd9, k, 4'd9, 4'd9);
        win(4'd9, k, 4'd9, 4'd9);
    endtask

    task automatic empty_win();
        win(4'd9, 4'd9, 4'd9, 4'd9);
    endtask

    initial begin
        reset             = 1'b0;
        kp_if.keyValue    = 4'd9;
        kp_if.evtReady    = 1'b1;
        kp_if.clrOverflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid",    int'(kp_if.evtValid), 0);
        check_val("rst_code",     int'(kp_if.evtCode),  0);
        check_val("rst_held",     int'(kp_if.heldKey),  9);
        check_val("rst_overflow", int'(kp_if.overflow), 0);
        reset = 1'b1;

        // Basic press of key 5, latency and release.
        win(4'd9, 4'd5, 4'd9, 4'd9);
        win(4'd9, 4'd5, 4'd9, 4'd9);
        check_val("p5_held_w1", int'(kp_if.heldKey), 9);
        exp_q.push_back(4'd5);
        win(4'd9, 4'd5, 4'd9, 4'd9);
        check_val("p5_valid", int'(kp_if.evtValid), 1);
        check_val("p5_held",  int'(kp_if.heldKey),  5);
        cyc(4'd9);
        check_val("p5_pulse", int'(kp_if.evtValid), 0);
        cyc(4'd9); cyc(4'd9); cyc(4'd9);
        check_val("p5_rel1", int'(kp_if.heldKey), 5);
        empty_win();
        check_val("p5_rel2", int'(kp_if.heldKey), 9);

        // Broken debounce: an empty window restarts the count.
        win(4'd9, 4'd5, 4'd9, 4'd9);
        win(4'd9, 4'd5, 4'd9, 4'd9);
        empty_win();
        win(4'd9, 4'd5, 4'd9, 4'd9);
        win(4'd9, 4'd5, 4'd9, 4'd9);
        check_val("gap_held_w4",  int'(kp_if.heldKey),  9);
        check_val("gap_valid_w4", int'(kp_if.evtValid), 0);
        exp_q.push_back(4'd5);
        win(4'd9, 4'd5, 4'd9, 4'd9);
        check_val("gap_held_w5", int'(kp_if.heldKey), 5);
        empty_win();
        empty_win();

        // Release bounce: one empty window does not release.
        exp_q.push_back(4'd2);
        press(4'd2);
        empty_win();
        check_val("bnc_e1", int'(kp_if.heldKey), 2);
        win(4'd2, 4'd9, 4'd9, 4'd9);
        check_val("bnc_c",  int'(kp_if.heldKey), 2);
        empty_win();
        check_val("bnc_e2", int'(kp_if.heldKey), 2);
        empty_win();
        check_val("bnc_e3", int'(kp_if.heldKey), 9);

        // Overflow: five presses into a depth-4 queue with no consumer.
        kp_if.evtReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back(4'(k));
            press(4'(k));
            empty_win();
            empty_win();
            if (k == 3) check_val("ovf_before", int'(kp_if.overflow), 0);
        end
        check_val("ovf_set",   int'(kp_if.overflow), 1);
        check_val("ovf_valid", int'(kp_if.evtValid), 1);
        check_val("ovf_head",  int'(kp_if.evtCode),  0);
        kp_if.evtReady = 1'b1;
        empty_win();
        check_val("ovf_drained", int'(kp_if.evtValid), 0);
        check_val("ovf_sticky",  int'(kp_if.overflow), 1);
        kp_if.clrOverflow = 1'b1;
        cyc(4'd9);
        kp_if.clrOverflow = 1'b0;
        cyc(4'd9); cyc(4'd9); cyc(4'd9);
        check_val("ovf_clr", int'(kp_if.overflow), 0);

        // Second key while held is ignored.
        exp_q.push_back(4'd3);
        press(4'd3);
        win(4'd9, 4'd3, 4'd7, 4'd9);
        check_val("cf_held",  int'(kp_if.heldKey),  3);
        check_val("cf_valid", int'(kp_if.evtValid), 0);
        win(4'd9, 4'd7, 4'd9, 4'd9);
        check_val("cf_other", int'(kp_if.heldKey), 3);
        empty_win();
        empty_win();
        check_val("cf_rel", int'(kp_if.heldKey), 9);

        // Conflict from IDLE must not start a press.
        win(4'd9, 4'd3, 4'd7, 4'd9);
        win(4'd9, 4'd3, 4'd9, 4'd9);
        win(4'd9, 4'd3, 4'd9, 4'd9);
        check_val("cf_idle", int'(kp_if.heldKey), 9);
        exp_q.push_back(4'd3);
        win(4'd9, 4'd3, 4'd9, 4'd9);
        check_val("cf_idle_conf", int'(kp_if.heldKey), 3);
        empty_win();
        empty_win();

        // Asynchronous reset with queued events and a press in progress.
        kp_if.evtReady = 1'b0;
        exp_q.push_back(4'd1);
        press(4'd1);
        empty_win();
        empty_win();
        exp_q.push_back(4'd2);
        press(4'd2);
        empty_win();
        empty_win();
        check_val("ar_queued", int'(kp_if.evtValid), 1);
        win(4'd9, 4'd4, 4'd9, 4'd9);
        win(4'd9, 4'd4, 4'd9, 4'd9);
        reset = 1'b0;
        #2;
        check_val("ar_valid",    int'(kp_if.evtValid), 0);
        check_val("ar_held",     int'(kp_if.heldKey),  9);
        check_val("ar_overflow", int'(kp_if.overflow), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        kp_if.evtReady = 1'b1;
        win(4'd9, 4'd4, 4'd9, 4'd9);
        win(4'd9, 4'd4, 4'd9, 4'd9);
        check_val("ar_restart_held",  int'(kp_if.heldKey),  9);
        check_val("ar_restart_valid", int'(kp_if.evtValid), 0);
        exp_q.push_back(4'd4);
        win(4'd9, 4'd4, 4'd9, 4'd9);
        check_val("ar_restart_conf", int'(kp_if.heldKey), 4);
        empty_win();
        empty_win();

        check_val("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_event_queue.md
# keypad_event_queue

Downstream stage of the 4x4 keypad scan/decoder. It consumes the per-cycle decoded key code (0–8 = key, 9 = none), debounces it across whole 4-cycle row-scan windows, and turns each confirmed press into a single event. Events are queued in a small FIFO behind a valid/ready handshake for the game/control logic. It also exposes the currently held key.

## Interface
- DEBOUNCE_WIN, 3, consecutive clean windows with the same key needed to confirm a press (1–7)
- RELEASE_WIN, 2, consecutive empty windows needed to confirm a release (1–7)
- FIFO_DEPTH, 4, event queue depth, power of two (2–16)

- clk_100Hz  in  1  scan clock, same clock as the keypad decoder
- reset  in  1  asynchronous, active-low
- keyValue  in  4  decoded key code from the decoder; 0–8 valid, 9–15 = none
- evtReady  in  1  consumer accepts the head event
- clrOverflow  in  1  clears the overflow flag
- evtValid  out  1  FIFO non-empty
- evtCode  out  4  head event key code (0–8)
- heldKey  out  4  debounced held key, 9 when none
- overflow  out  1  sticky: a confirmed press was dropped because the FIFO was full

## Operation
- A free-running 2-bit phase counter runs 0..3. One window = 4 cycles, aligned to the decoder row rotation.
- Per-window sampling, every cycle:
  - A code of 9–15 is ignored.
  - The first code 0–8 seen in the window is latched as winCode.
  - A different code 0–8 in the same window sets conflict.
- The window is evaluated on the cycle with phase==3, including that cycle's sample. The window class is:
  - EMPTY: no code seen
  - CLEAN(k): one code k, no conflict
  - CONFLICT: conflict set
- winCode and conflict clear for the next window.
- FSM states IDLE, PRESSING, HELD, RELEASING; registers cand[3:0], cnt[2:0]:
  - IDLE:
    - CLEAN(k): cand=k, cnt=1, go to PRESSING.
    - If DEBOUNCE_WIN==1, go straight to HELD and push k.
    - Otherwise stay.
  - PRESSING:
    - CLEAN(cand): cnt+1. On reaching DEBOUNCE_WIN, go to HELD and push cand.
    - CLEAN(other j): cand=j, cnt=1.
    - EMPTY or CONFLICT: go to IDLE.
  - HELD:
    - CLEAN(cand): stay, cnt=0.
    - EMPTY: cnt=1, go to RELEASING. If RELEASE_WIN==1, go to IDLE instead.
    - CLEAN(other) or CONFLICT: stay HELD, cnt=0, no event (second key ignored).
  - RELEASING:
    - EMPTY: cnt+1. On reaching RELEASE_WIN, go to IDLE.
    - CLEAN(cand): go to HELD, cnt=0, no new event.
    - CLEAN(other j): cand=j, cnt=1, go to PRESSING.
    - CONFLICT: go to IDLE.
- heldKey = cand in HELD/RELEASING, otherwise 9.
- FIFO:
  - Push on press confirmation.
  - Pop when evtValid && evtReady.
  - evtCode = head entry, first-word fall-through.
  - Push while full with no pop: event dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Pop while empty: ignored.
- overflow holds until clrOverflow is seen. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: phase 0, state IDLE, cand 0, cnt 0, FIFO empty, evtValid 0, evtCode 0, heldKey 9, overflow 0.
- Reset asserted mid-operation discards the FSM and all queued events immediately (async). Operation restarts at phase 0 after release.
- The FSM updates on the phase==3 edge. heldKey and the push take effect together.
- evtValid and evtCode update the cycle after the push edge.
- Press latency: evtValid rises on the clock after the phase==3 cycle of the DEBOUNCE_WIN-th consecutive CLEAN window.
- Release latency: heldKey returns to 9 after the RELEASE_WIN-th EMPTY window.
- Handshake: evtCode is stable while evtValid=1 and evtReady=0. The next entry appears the cycle after the pop. Back-to-back pops are allowed every cycle.

## Test plan
- Key 5 present at phase 1 of windows 0,1,2 (9 elsewhere), defaults, evtReady=1: evtValid pulses one cycle after cycle 11 with evtCode=5; heldKey=5 from cycle 12.
- Key 5 held for windows 0–1, window 2 EMPTY, key 5 in windows 3–5: no event until window 5 end; exactly one event of code 5.
- Held key 2, then windows EMPTY, CLEAN(2), EMPTY, EMPTY: heldKey stays 2 through the bounce and becomes 9 after the second EMPTY; only one event total.
- evtReady=0, confirm presses 0,1,2,3,4: FIFO holds 0..3 and overflow=1. Drain with evtReady=1: codes 0,1,2,3 in order, evtValid drops after the 4th. clrOverflow clears the flag.
- Keys 3 and 7 in the same window while HELD on 3: stays HELD, heldKey=3, no event. From IDLE, the same CONFLICT produces no transition.
- Assert reset with 2 queued events while PRESSING: evtValid=0, heldKey=9, overflow=0 immediately; no event is emitted for the interrupted press.
